// File: rtl/core_debug_ctrl.sv
// Host-side run/debug controller for the single-cycle RV32 core.
// Ports: clk/reset (sync, active-low); cmd_* valid/ready command in;
// rsp_* valid/ready response out; core_rst/core_clk_en sequence the core;
// inst_* write instruction memory; debug_* read regfile/dmem/imem while
// halted; running and cycle_count report core status.
module core_debug_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int READ_LAT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        core_rst,
  output logic        core_clk_en,
  output logic        inst_we,
  output logic [31:0] inst_wr_addr,
  output logic [31:0] inst_wr_data,
  output logic        debug_en,
  output logic [4:0]  debug_reg_addr,
  output logic [31:0] debug_inst_addr,
  output logic [31:0] debug_mem_addr,
  input  logic [31:0] debug_inst_data,
  input  logic [31:0] debug_reg_data,
  input  logic [31:0] debug_mem_data,
  output logic        running,
  output logic [31:0] cycle_count
);

  typedef enum logic [2:0] {
    S_CRST, S_HALTED, S_RUN, S_STEP, S_WRITE, S_READ, S_RESP
  } state_t;

  localparam logic [2:0] OP_RST  = 3'd0;
  localparam logic [2:0] OP_HALT = 3'd1;
  localparam logic [2:0] OP_RUN  = 3'd2;
  localparam logic [2:0] OP_STEP = 3'd3;
  localparam logic [2:0] OP_WR   = 3'd4;

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] step_n;
  logic        from_cmd;
  logic        ret_run;
  logic [1:0]  rd_sel;
  logic [31:0] cc_next;
  logic [31:0] step_req;
  logic [31:0] rd_data;

  assign cmd_ready = (state == S_HALTED) || (state == S_RUN);
  // Count value after this edge; responses report the post-edge count.
  assign cc_next  = cycle_count + {31'd0, core_clk_en & ~core_rst};
  assign step_req = (cmd_data == 32'd0) ? 32'd1 : cmd_data;

  always_comb begin
    rd_data = debug_inst_data;
    unique case (rd_sel)
      2'd1:    rd_data = debug_reg_data;
      2'd2:    rd_data = debug_mem_data;
      default: rd_data = debug_inst_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= S_CRST;
      cnt             <= '0;
      step_n          <= '0;
      from_cmd        <= 1'b0;
      ret_run         <= 1'b0;
      rd_sel          <= '0;
      core_rst        <= 1'b1;
      core_clk_en     <= 1'b1;
      rsp_valid       <= 1'b0;
      rsp_data        <= '0;
      rsp_err         <= 1'b0;
      inst_we         <= 1'b0;
      inst_wr_addr    <= '0;
      inst_wr_data    <= '0;
      debug_en        <= 1'b0;
      debug_reg_addr  <= '0;
      debug_inst_addr <= '0;
      debug_mem_addr  <= '0;
      running         <= 1'b0;
      cycle_count     <= '0;
    end else begin
      cycle_count <= cc_next;
      unique case (state)
        S_CRST: begin
          if (cnt == 32'(RST_CYCLES - 1)) begin
            core_rst    <= 1'b0;
            core_clk_en <= 1'b0;
            cycle_count <= '0;
            ret_run     <= 1'b0;
            if (from_cmd) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_err   <= 1'b0;
            end else begin
              state <= S_HALTED;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_HALTED: begin
          if (cmd_valid) begin
            rsp_err <= 1'b0;
            ret_run <= 1'b0;
            unique case (cmd_op)
              OP_RST: begin
                state       <= S_CRST;
                from_cmd    <= 1'b1;
                core_rst    <= 1'b1;
                core_clk_en <= 1'b1;
                cnt         <= '0;
              end
              OP_HALT: begin
                state     <= S_RESP;
                rsp_valid <= 1'b1;
                rsp_data  <= cc_next;
              end
              OP_RUN: begin
                state       <= S_RESP;
                ret_run     <= 1'b1;
                running     <= 1'b1;
                core_clk_en <= 1'b1;
                rsp_valid   <= 1'b1;
                rsp_data    <= cc_next;
              end
              OP_STEP: begin
                state       <= S_STEP;
                running     <= 1'b1;
                core_clk_en <= 1'b1;
                step_n      <= step_req;
                cnt         <= step_req - 32'd1;
              end
              OP_WR: begin
                state        <= S_WRITE;
                inst_we      <= 1'b1;
                inst_wr_addr <= cmd_addr;
                inst_wr_data <= cmd_data;
                rsp_data     <= cmd_data;
              end
              default: begin
                // 5 READ_REG, 6 READ_MEM, 7 READ_INST
                state    <= S_READ;
                debug_en <= 1'b1;
                rd_sel   <= cmd_op[1:0];
                cnt      <= 32'(READ_LAT);
                unique case (cmd_op[1:0])
                  2'd1:    debug_reg_addr  <= cmd_addr[4:0];
                  2'd2:    debug_mem_addr  <= cmd_addr;
                  default: debug_inst_addr <= cmd_addr;
                endcase
              end
            endcase
          end
        end
        S_RUN: begin
          if (cmd_valid) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            ret_run   <= 1'b1;
            unique case (cmd_op)
              OP_RST: begin
                state       <= S_CRST;
                rsp_valid   <= 1'b0;
                from_cmd    <= 1'b1;
                core_rst    <= 1'b1;
                running     <= 1'b0;
                cnt         <= '0;
              end
              OP_HALT: begin
                ret_run     <= 1'b0;
                running     <= 1'b0;
                core_clk_en <= 1'b0;
                rsp_data    <= cc_next;
              end
              OP_RUN: rsp_data <= cc_next;
              default: begin
                rsp_err  <= 1'b1;
                rsp_data <= '0;
              end
            endcase
          end
        end
        S_STEP: begin
          if (cnt == 32'd0) begin
            state       <= S_RESP;
            core_clk_en <= 1'b0;
            running     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_data    <= step_n;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        S_WRITE: begin
          inst_we   <= 1'b0;
          state     <= S_RESP;
          rsp_valid <= 1'b1;
        end
        S_READ: begin
          if (cnt == 32'd0) begin
            debug_en  <= 1'b0;
            rsp_data  <= rd_data;
            state     <= S_RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            state     <= ret_run ? S_RUN : S_HALTED;
          end
        end
        default: state <= S_HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_core_debug_ctrl.sv
// Scoreboard testbench for core_debug_ctrl.
// Stimulus pushes expected responses; a monitor pops and compares them.
module tb_core_debug_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        core_rst;
  logic        core_clk_en;
  logic        inst_we;
  logic [31:0] inst_wr_addr;
  logic [31:0] inst_wr_data;
  logic        debug_en;
  logic [4:0]  debug_reg_addr;
  logic [31:0] debug_inst_addr;
  logic [31:0] debug_mem_addr;
  logic [31:0] debug_inst_data;
  logic [31:0] debug_reg_data;
  logic [31:0] debug_mem_data;
  logic        running;
  logic [31:0] cycle_count;

  always #5 clk = ~clk;

  core_debug_ctrl #(.RST_CYCLES(2), .READ_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_rst(core_rst), .core_clk_en(core_clk_en),
    .inst_we(inst_we), .inst_wr_addr(inst_wr_addr),
    .inst_wr_data(inst_wr_data),
    .debug_en(debug_en), .debug_reg_addr(debug_reg_addr),
    .debug_inst_addr(debug_inst_addr), .debug_mem_addr(debug_mem_addr),
    .debug_inst_data(debug_inst_data), .debug_reg_data(debug_reg_data),
    .debug_mem_data(debug_mem_data),
    .running(running), .cycle_count(cycle_count)
  );

  // m=1: expected data is the bench's own count of enabled core cycles
  typedef struct packed {
    logic [31:0] d;
    logic        e;
    logic        m;
  } exp_t;

  exp_t        q[$];
  exp_t        x;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] en_cnt = '0;
  int          we_cnt = 0;
  int          dbg_cnt = 0;
  int          viol = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor + bench-side counters
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got data=%h err=%b required none",
                 rsp_data, rsp_err);
      end else begin
        x = q.pop_front();
        if (rsp_data !== (x.m ? en_cnt : x.d) || rsp_err !== x.e) begin
          errors++;
          $display("FAIL rsp: got data=%h err=%b required data=%h err=%b",
                   rsp_data, rsp_err, x.m ? en_cnt : x.d, x.e);
        end
      end
    end
    if (core_rst) en_cnt = '0;
    else if (core_clk_en) en_cnt = en_cnt + 32'd1;
    if (inst_we) we_cnt++;
    if (debug_en) dbg_cnt++;
    if ((debug_en || inst_we) && core_clk_en) viol++;
  end

  task automatic push(input logic [31:0] d, input logic e, input logic m);
    exp_t t;
    t.d = d; t.e = e; t.m = m;
    q.push_back(t);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] d);
    int k;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    for (k = 0; k < 300 && !cmd_ready; k++) @(negedge clk);
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_timeout: got cmd_ready=0 required 1");
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int k;
    for (k = 0; k < 500 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: got pending=%0d required 0", q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    int n, we0, dbg0;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0;
    cmd_data = '0; rsp_ready = 1'b1;
    debug_inst_data = 32'h0050_0093;
    debug_reg_data  = 32'h1111_0005;
    debug_mem_data  = 32'h2222_0000;
    repeat (3) @(negedge clk);
    chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
    chk("rst_clk_en", {31'd0, core_clk_en}, 32'd1);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_cycle_count", cycle_count, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (core_rst) n++;
      else break;
    end
    chk("crst_cycles", n, 32'd2);
    chk("halted_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("halted_clk_en", {31'd0, core_clk_en}, 32'd0);
    chk("halted_cycle_count", cycle_count, 32'd0);

    // Instruction write then readback
    we0 = we_cnt;
    push(32'h0050_0093, 1'b0, 1'b0);
    issue(3'd4, 32'h8, 32'h0050_0093);
    @(negedge clk);
    chk("wr_inst_we", {31'd0, inst_we}, 32'd1);
    chk("wr_addr", inst_wr_addr, 32'h8);
    chk("wr_data", inst_wr_data, 32'h0050_0093);
    wait_rsp();
    chk("wr_pulses", we_cnt - we0, 32'd1);

    dbg0 = dbg_cnt;
    push(32'h0050_0093, 1'b0, 1'b0);
    issue(3'd7, 32'h8, 32'h0);
    @(negedge clk);
    chk("rd_debug_en", {31'd0, debug_en}, 32'd1);
    chk("rd_inst_addr", debug_inst_addr, 32'h8);
    wait_rsp();
    chk("rd_en_cycles", dbg_cnt - dbg0, 32'd2);

    push(32'h1111_0005, 1'b0, 1'b0);
    issue(3'd5, 32'h25, 32'h0);
    @(negedge clk);
    chk("rd_reg_addr", {27'd0, debug_reg_addr}, 32'd5);
    wait_rsp();

    // Stepping
    push(32'd3, 1'b0, 1'b0);
    issue(3'd3, 32'h0, 32'd3);
    wait_rsp();
    chk("step3_count", cycle_count, 32'd3);
    chk("step3_model", en_cnt, 32'd3);
    push(32'd1, 1'b0, 1'b0);
    issue(3'd3, 32'h0, 32'd0);
    wait_rsp();
    chk("step0_count", cycle_count, 32'd4);

    // Run, then halt
    push(32'd4, 1'b0, 1'b0);
    issue(3'd2, 32'h0, 32'h0);
    wait_rsp();
    chk("run_running", {31'd0, running}, 32'd1);
    repeat (10) @(negedge clk);
    push(32'd0, 1'b0, 1'b1);
    issue(3'd1, 32'h0, 32'h0);
    @(negedge clk);
    chk("halt_clk_en", {31'd0, core_clk_en}, 32'd0);
    wait_rsp();
    chk("halt_count_model", cycle_count, en_cnt);

    // Rejected read while running
    push(cycle_count, 1'b0, 1'b0);
    issue(3'd2, 32'h0, 32'h0);
    wait_rsp();
    dbg0 = dbg_cnt;
    push(32'd0, 1'b1, 1'b0);
    issue(3'd5, 32'd5, 32'h0);
    @(negedge clk);
    chk("rej_running", {31'd0, running}, 32'd1);
    wait_rsp();
    chk("rej_debug_en", dbg_cnt - dbg0, 32'd0);
    chk("rej_still_run", {31'd0, core_clk_en}, 32'd1);
    push(32'd0, 1'b0, 1'b1);
    issue(3'd1, 32'h0, 32'h0);
    wait_rsp();

    // Reset mid-STEP drops the response
    issue(3'd3, 32'h0, 32'd100);
    repeat (40) @(negedge clk);
    chk("step_mid_running", {31'd0, running}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_core_rst", {31'd0, core_rst}, 32'd1);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_cycle_count", cycle_count, 32'd0);
    chk("abort_running", {31'd0, running}, 32'd0);
    reset = 1'b1;
    for (int k = 0; k < 20 && core_rst; k++) @(negedge clk);
    chk("abort_recovered", {31'd0, core_rst}, 32'd0);

    // Backpressure on the response
    rsp_ready = 1'b0;
    push(32'd0, 1'b0, 1'b0);
    issue(3'd1, 32'h0, 32'h0);
    repeat (20) @(negedge clk);
    chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_rsp();

    chk("no_debug_while_clocked", viol, 32'd0);
    chk("queue_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
